video_roi_downsample: RTL and testbench

- Sits directly downstream of the image preprocessing interface.
- Consumes its pass-through video stream together with the parsed pixel coordinates, frame format and frame flags.
- Crops a fixed region of interest (ROI), converts RGB888 to 8-bit luma, and box-averages SCALE×SCALE blocks.
- Emits an OUT_W×OUT_H grayscale pixel stream for the CNN input buffer.

---
 rtl/video_roi_downsample.sv | 131 +++++++++++++
 tb/tb_video_roi_downsample.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_roi_downsample.sv
// Crops a fixed ROI from RGB888 video, converts to 8-bit luma and box-averages SCALExSCALE blocks.
// Latency: 3 cycles from a block's final input pixel to o_pix_valid; no back-pressure (<=1 output per SCALE inputs).
module video_roi_downsample #(
  parameter int unsigned ROI_X0     = 0,
  parameter int unsigned ROI_Y0     = 0,
  parameter int unsigned OUT_W      = 28,
  parameter int unsigned OUT_H      = 28,
  parameter int unsigned SCALE_LOG2 = 3
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic [23:0] i_video_data,
  input  logic        i_video_vde,
  input  logic [11:0] i_video_x,
  input  logic [11:0] i_video_y,
  input  logic [11:0] i_video_format_x,
  input  logic [11:0] i_video_format_y,
  input  logic        i_video_change,
  output logic [7:0]  o_pix_data,
  output logic        o_pix_valid,
  output logic        o_pix_first,
  output logic        o_pix_last,
  output logic        o_frame_done,
  output logic        o_roi_err
);
  localparam int unsigned SCALE    = 1 << SCALE_LOG2;
  localparam int unsigned AW       = 8 + 2 * SCALE_LOG2;
  localparam int unsigned BXW      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [12:0] ROI_W    = 13'(OUT_W * SCALE);
  localparam logic [12:0] ROI_H    = 13'(OUT_H * SCALE);
  localparam logic [12:0] X_END    = 13'(ROI_X0 + OUT_W * SCALE);
  localparam logic [12:0] Y_END    = 13'(ROI_Y0 + OUT_H * SCALE);
  localparam logic [11:0] SUB_MASK = 12'(SCALE - 1);
  localparam logic [11:0] LAST_IDX = 12'(OUT_W * OUT_H - 1);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t        state_q;
  logic          vld1_q, vld2_q;
  logic [11:0]   x1_q, y1_q, x2_q, y2_q;
  logic [15:0]   rg1_q;
  logic [12:0]   b1_q;
  logic [7:0]    luma2_q;
  logic [11:0]   out_cnt_q;
  logic [AW-1:0] acc_q [OUT_W];

  logic [12:0]    dx, dy;
  logic [11:0]    sub_x, sub_y;
  logic [BXW-1:0] bx;
  logic [AW-1:0]  acc_d;
  logic           in_roi, blk_first, blk_last, run, origin, fmt_ok;

  // A pixel left of / above the ROI wraps dx/dy to a huge value, so one compare per axis suffices.
  always_comb begin
    dx        = {1'b0, x2_q} - 13'(ROI_X0);
    dy        = {1'b0, y2_q} - 13'(ROI_Y0);
    in_roi    = vld2_q && (dx < ROI_W) && (dy < ROI_H);
    sub_x     = dx[11:0] & SUB_MASK;
    sub_y     = dy[11:0] & SUB_MASK;
    blk_first = (sub_x == '0) && (sub_y == '0);
    blk_last  = (sub_x == SUB_MASK) && (sub_y == SUB_MASK);
    bx        = BXW'(dx[11:0] >> SCALE_LOG2);
    // Combinational regfile read: the next pixel of the same block already sees this cycle's write.
    acc_d     = blk_first ? AW'(luma2_q) : acc_q[bx] + AW'(luma2_q);
    run       = (state_q != IDLE) && in_roi;
    origin    = i_video_vde && (i_video_x == '0) && (i_video_y == '0);
    fmt_ok    = ({1'b0, i_video_format_x} >= X_END) && ({1'b0, i_video_format_y} >= Y_END);
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      vld1_q       <= 1'b0;
      vld2_q       <= 1'b0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      rg1_q        <= '0;
      b1_q         <= '0;
      luma2_q      <= '0;
      out_cnt_q    <= '0;
      o_pix_data   <= '0;
      o_pix_valid  <= 1'b0;
      o_pix_first  <= 1'b0;
      o_pix_last   <= 1'b0;
      o_frame_done <= 1'b0;
      o_roi_err    <= 1'b0;
      for (int i = 0; i < int'(OUT_W); i++) acc_q[i] <= '0;
    end else begin
      o_pix_valid  <= 1'b0;
      o_pix_first  <= 1'b0;
      o_pix_last   <= 1'b0;
      o_frame_done <= 1'b0;

      vld1_q  <= i_video_vde;
      x1_q    <= i_video_x;
      y1_q    <= i_video_y;
      rg1_q   <= 16'(i_video_data[23:16]) * 16'd77 + 16'(i_video_data[15:8]) * 16'd150;
      b1_q    <= 13'(i_video_data[7:0]) * 13'd29;
      vld2_q  <= vld1_q;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      luma2_q <= 8'((rg1_q + 16'(b1_q)) >> 8);

      if (i_video_change) begin
        state_q <= IDLE;
        vld1_q  <= 1'b0;
        vld2_q  <= 1'b0;
      end else if (origin) begin
        // New frame: drop in-flight pixels of the old one and re-check the format.
        vld2_q    <= 1'b0;
        out_cnt_q <= '0;
        o_roi_err <= !fmt_ok;
        state_q   <= fmt_ok ? ARMED : IDLE;
      end else if (run) begin
        acc_q[bx] <= acc_d;
        if (state_q == ARMED) state_q <= ACTIVE;
        if (blk_last) begin
          o_pix_valid  <= 1'b1;
          o_pix_data   <= 8'(acc_d >> (2 * SCALE_LOG2));
          o_pix_first  <= (out_cnt_q == '0);
          o_pix_last   <= (out_cnt_q == LAST_IDX);
          o_frame_done <= (out_cnt_q == LAST_IDX);
          out_cnt_q    <= out_cnt_q + 12'd1;
          if (out_cnt_q == LAST_IDX) state_q <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_video_roi_downsample.sv
// Four parameterisations of video_roi_downsample share one stimulus stream; a frame-buffer
// reference computes each expected block average and a negedge monitor scores every output.
module tb_video_roi_downsample;
  localparam int NI = 4;
  localparam int P_X0 [NI] = '{0, 8, 3, 5};
  localparam int P_Y0 [NI] = '{0, 4, 2, 1};
  localparam int P_W  [NI] = '{28, 4, 5, 6};
  localparam int P_H  [NI] = '{28, 2, 3, 4};
  localparam int P_SL [NI] = '{3, 1, 2, 0};

  typedef struct packed {
    logic [7:0] dat;
    logic       first;
    logic       last;
    int         cyc;
  } exp_t;

  logic        i_pclk = 1'b0;
  logic        i_rst;
  logic [23:0] vdata;
  logic        vde;
  logic [11:0] vx, vy, fmtx, fmty;
  logic        vchg;
  logic [7:0]  pd [NI];
  logic        pv [NI];
  logic        pf [NI];
  logic        pl [NI];
  logic        fd [NI];
  logic        re [NI];

  exp_t       exp_q [NI][$];
  exp_t       e;
  bit         armed [NI];
  bit         exp_err [NI];
  int         oidx [NI];
  logic [7:0] lumbuf [0:223][0:223];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int chk_req = 0;
  int chk_seen = 0;
  int chk_kind = 0;
  bit mon_en = 1'b0;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    video_roi_downsample #(
      .ROI_X0(P_X0[k]), .ROI_Y0(P_Y0[k]), .OUT_W(P_W[k]), .OUT_H(P_H[k]), .SCALE_LOG2(P_SL[k])
    ) u_dut (
      .i_pclk(i_pclk), .i_rst(i_rst), .i_video_data(vdata), .i_video_vde(vde),
      .i_video_x(vx), .i_video_y(vy), .i_video_format_x(fmtx), .i_video_format_y(fmty),
      .i_video_change(vchg), .o_pix_data(pd[k]), .o_pix_valid(pv[k]), .o_pix_first(pf[k]),
      .o_pix_last(pl[k]), .o_frame_done(fd[k]), .o_roi_err(re[k])
    );
  end

  initial forever #5 i_pclk = ~i_pclk;
  always @(posedge i_pclk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  always @(negedge i_pclk) begin
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (pv[k] === 1'b1) begin
          if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL dut%0d_unexpected: got data=%0d first=%0b last=%0b, expected no output",
                     k, pd[k], pf[k], pl[k]);
          end else begin
            e = exp_q[k].pop_front();
            if (pd[k] !== e.dat || pf[k] !== e.first || pl[k] !== e.last || fd[k] !== e.last ||
                (cyc - e.cyc) != 3) begin
              n_fail++;
              $display("FAIL dut%0d_pixel: got data=%0d first=%0b last=%0b done=%0b lat=%0d, expected data=%0d first=%0b last=%0b done=%0b lat=3",
                       k, pd[k], pf[k], pl[k], fd[k], cyc - e.cyc, e.dat, e.first, e.last, e.last);
            end
          end
        end else if ({pv[k], pf[k], pl[k], fd[k]} !== 4'b0000) begin
          n_fail++;
          $display("FAIL dut%0d_idle_flags: got valid=%b first=%b last=%b done=%b, expected all 0",
                   k, pv[k], pf[k], pl[k], fd[k]);
        end
      end
      if (chk_req != chk_seen) begin
        chk_seen = chk_req;
        for (int k = 0; k < NI; k++) begin
          n_cmp++;
          case (chk_kind)
            0: if (re[k] !== exp_err[k]) begin
                 n_fail++;
                 $display("FAIL dut%0d_roi_err: got %b, expected %b", k, re[k], exp_err[k]);
               end
            1: if ({pd[k], pv[k], pf[k], pl[k], fd[k], re[k]} !== 13'd0) begin
                 n_fail++;
                 $display("FAIL dut%0d_reset_zero: got data=%h valid=%b first=%b last=%b done=%b err=%b, expected all 0",
                          k, pd[k], pv[k], pf[k], pl[k], fd[k], re[k]);
               end
            default: if (exp_q[k].size() != 0) begin
                 n_fail++;
                 $display("FAIL dut%0d_missing: %0d outputs never appeared, expected 0", k, exp_q[k].size());
               end
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_pclk);
    #1;
  endtask

  task automatic request_check(input int kind);
    chk_kind = kind;
    chk_req++;
  endtask

  function automatic int luma(input logic [23:0] c);
    return (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) / 256;
  endfunction

  // Reference: a block's average becomes due the moment its bottom-right pixel is issued.
  task automatic model_pixel(input int x, input int y, input int fx, input int fy);
    int s, sum, n;
    exp_t it;
    for (int k = 0; k < NI; k++) begin
      s = 1 << P_SL[k];
      n = P_W[k] * P_H[k];
      if (x == 0 && y == 0) begin
        armed[k]   = (P_X0[k] + P_W[k] * s <= fx) && (P_Y0[k] + P_H[k] * s <= fy);
        exp_err[k] = !armed[k];
        oidx[k]    = 0;
      end
      if (armed[k] && x >= P_X0[k] && x < P_X0[k] + P_W[k] * s && y >= P_Y0[k] &&
          y < P_Y0[k] + P_H[k] * s && (x - P_X0[k]) % s == s - 1 && (y - P_Y0[k]) % s == s - 1) begin
        sum = 0;
        for (int yy = y - s + 1; yy <= y; yy++)
          for (int xx = x - s + 1; xx <= x; xx++)
            sum += int'(lumbuf[yy][xx]);
        it.dat   = 8'(sum / (s * s));
        it.first = (oidx[k] == 0);
        it.last  = (oidx[k] == n - 1);
        it.cyc   = cyc;
        exp_q[k].push_back(it);
        oidx[k]++;
        if (oidx[k] == n) armed[k] = 1'b0;
      end
    end
  endtask

  // mode 0 white, 1 grey (x+y), 2 random; ev_kind 1 = video_change, 2 = reset, in blanking after ev_row.
  task automatic run_frame(input int fx, input int fy, input int dw, input int dh, input int mode,
                           input bit gap, input int ev_row, input int ev_kind);
    int np;
    logic [23:0] c;
    logic [7:0] g;
    np = 0;
    fmtx = 12'(fx);
    fmty = 12'(fy);
    for (int y = 0; y < dh; y++) begin
      for (int x = 0; x < dw; x++) begin
        if (gap && np > 0 && np % 16 == 0) begin
          vde = 1'b0; vx = '0; vy = '0;
          repeat (4) tick();
        end
        g = 8'(x + y);
        case (mode)
          0: c = 24'hFFFFFF;
          1: c = {g, g, g};
          default: c = 24'($urandom());
        endcase
        lumbuf[y][x] = 8'(luma(c));
        vde = 1'b1; vx = 12'(x); vy = 12'(y); vdata = c;
        model_pixel(x, y, fx, fy);
        tick();
        np++;
      end
      vde = 1'b0; vx = '0; vy = '0;
      for (int b = 0; b < 6; b++) begin
        if (b == 4 && y == ev_row && ev_kind == 1) begin
          vchg = 1'b1;
          for (int k = 0; k < NI; k++) armed[k] = 1'b0;
          tick();
          vchg = 1'b0;
        end else if (b == 4 && y == ev_row && ev_kind == 2) begin
          i_rst = 1'b1;
          for (int k = 0; k < NI; k++) begin
            armed[k] = 1'b0;
            exp_err[k] = 1'b0;
          end
          tick();
          i_rst = 1'b0;
          request_check(1);
        end else begin
          tick();
        end
      end
    end
    repeat (4) tick();
    request_check(0);
    tick();
    tick();
  endtask

  initial begin
    int fx, fy;
    i_rst = 1'b1; vde = 1'b0; vx = '0; vy = '0; vdata = '0; fmtx = '0; fmty = '0; vchg = 1'b0;
    for (int k = 0; k < NI; k++) begin
      armed[k] = 1'b0; exp_err[k] = 1'b0; oidx[k] = 0;
    end
    repeat (3) tick();
    i_rst = 1'b0;
    mon_en = 1'b1;
    request_check(1);
    tick();

    run_frame(200, 480, 24, 16, 2, 1'b0, -1, 0);
    run_frame(640, 480, 224, 224, 0, 1'b0, -1, 0);
    run_frame(24, 16, 24, 16, 1, 1'b0, -1, 0);
    run_frame(32, 20, 32, 20, 2, 1'b0, 9, 1);
    run_frame(32, 20, 32, 20, 2, 1'b0, -1, 0);
    run_frame(32, 20, 32, 20, 2, 1'b0, 7, 2);
    run_frame(32, 20, 32, 20, 2, 1'b1, -1, 0);
    run_frame(32, 20, 32, 10, 2, 1'b1, -1, 0);
    for (int f = 0; f < 4; f++) begin
      fx = int'($urandom_range(12, 40));
      fy = int'($urandom_range(6, 20));
      run_frame(fx, fy, fx, fy, 2, 1'($urandom_range(0, 1)), -1, 0);
    end
    run_frame(32, 20, 32, 20, 1, 1'b0, -1, 0);

    request_check(2);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
